// File: rtl/generic_sram_byte_en_arb.sv
// generic_sram_byte_en_arb
// Two-requester arbiter in front of a single-port SRAM with byte enables and
// registered read data. Grants are combinational. The accepted command is
// registered onto the SRAM pins one cycle after the grant. Read data comes back
// to the owning requester two cycles after the grant.
//
// Build option: define GENERIC_SRAM_BYTE_EN_ARB_RR_EN to get round-robin
// arbitration. Without it, requester 0 has fixed priority.
module generic_sram_byte_en_arb #(
    parameter int ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH    = 128
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,

    input  logic                      i_p0_req,
    input  logic                      i_p0_we,
    input  logic [ADDRESS_WIDTH-1:0]  i_p0_addr,
    input  logic [DATA_WIDTH-1:0]     i_p0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_p0_be,
    output logic                      o_p0_gnt,
    output logic                      o_p0_rvalid,
    output logic [DATA_WIDTH-1:0]     o_p0_rdata,

    input  logic                      i_p1_req,
    input  logic                      i_p1_we,
    input  logic [ADDRESS_WIDTH-1:0]  i_p1_addr,
    input  logic [DATA_WIDTH-1:0]     i_p1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_p1_be,
    output logic                      o_p1_gnt,
    output logic                      o_p1_rvalid,
    output logic [DATA_WIDTH-1:0]     o_p1_rdata,

    output logic [ADDRESS_WIDTH-1:0]  o_sram_address,
    output logic [DATA_WIDTH-1:0]     o_sram_write_data,
    output logic                      o_sram_write_enable,
    output logic [DATA_WIDTH/8-1:0]   o_sram_byte_enable,
    input  logic [DATA_WIDTH-1:0]     i_sram_read_data
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                     gnt0;
    logic                     gnt1;
    logic                     any_gnt;

    // Registered SRAM command
    logic [ADDRESS_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     we_q,    we_d;
    logic [BE_WIDTH-1:0]      be_q,    be_d;

    // Read-owner pipeline: stage 1 matches the SRAM command cycle, and stage 2
    // matches the cycle in which the SRAM read data is valid.
    logic                     rd1_v_q,   rd1_v_d;
    logic                     rd1_own_q, rd1_own_d;
    logic                     rd2_v_q;
    logic                     rd2_own_q;

`ifdef GENERIC_SRAM_BYTE_EN_ARB_RR_EN
    // 1 when requester 1 received the most recent grant
    logic                     last_q, last_d;

    // Round-robin grant: on contention, the requester that was not granted last wins
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rst_n) begin
            if (i_p0_req && (!i_p1_req || last_q)) begin
                gnt0 = 1'b1;
            end else if (i_p1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Pointer next state: follows every accepted command
    always_comb begin
        last_d = last_q;
        if (any_gnt) begin
            last_d = gnt1;
        end
    end

    // Pointer register; reset says requester 1 was last, so requester 0 wins first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed-priority grant: requester 0 always wins
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rst_n) begin
            if (i_p0_req) begin
                gnt0 = 1'b1;
            end else if (i_p1_req) begin
                gnt1 = 1'b1;
            end
        end
    end
`endif

    assign any_gnt = gnt0 | gnt1;

    // Next-state logic: capture the accepted command, otherwise hold and drop write enable
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = 1'b0;
        rd1_v_d   = 1'b0;
        rd1_own_d = rd1_own_q;
        if (any_gnt) begin
            addr_d    = gnt1 ? i_p1_addr  : i_p0_addr;
            wdata_d   = gnt1 ? i_p1_wdata : i_p0_wdata;
            we_d      = gnt1 ? i_p1_we    : i_p0_we;
            // Reads present all-zero byte enables; writes pass the enables through unchanged
            be_d      = we_d ? (gnt1 ? i_p1_be : i_p0_be) : '0;
            rd1_v_d   = !we_d;
            rd1_own_d = gnt1;
        end
    end

    // SRAM command register and read-owner pipeline; reset discards reads in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            rd1_v_q   <= 1'b0;
            rd1_own_q <= 1'b0;
            rd2_v_q   <= 1'b0;
            rd2_own_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            be_q      <= be_d;
            rd1_v_q   <= rd1_v_d;
            rd1_own_q <= rd1_own_d;
            rd2_v_q   <= rd1_v_q;
            rd2_own_q <= rd1_own_q;
        end
    end

    assign o_p0_gnt            = gnt0;
    assign o_p1_gnt            = gnt1;

    assign o_sram_address      = addr_q;
    assign o_sram_write_data   = wdata_q;
    assign o_sram_write_enable = we_q;
    assign o_sram_byte_enable  = be_q;

    // Read data is steered to the owner only, and is zero whenever it is not valid
    assign o_p0_rvalid = rd2_v_q & ~rd2_own_q;
    assign o_p1_rvalid = rd2_v_q &  rd2_own_q;
    assign o_p0_rdata  = o_p0_rvalid ? i_sram_read_data : '0;
    assign o_p1_rdata  = o_p1_rvalid ? i_sram_read_data : '0;

endmodule

// File: tb/tb_generic_sram_byte_en_arb.sv
// Testbench for generic_sram_byte_en_arb: table-driven single accesses, then
// hand-written contention, read-after-write and reset-mid-operation sequences.
// A behavioural SRAM (registered read, byte-enabled write) sits on the SRAM pins.
module tb_generic_sram_byte_en_arb;

    localparam int AW  = 7;
    localparam int DW  = 128;
    localparam int BEW = DW / 8;

    logic           clk;
    logic           rst_n;
    logic           p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0]  p0_addr;
    logic [DW-1:0]  p0_wdata, p0_rdata;
    logic [BEW-1:0] p0_be;
    logic           p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0]  p1_addr;
    logic [DW-1:0]  p1_wdata, p1_rdata;
    logic [BEW-1:0] p1_be;
    logic [AW-1:0]  sram_addr;
    logic [DW-1:0]  sram_wdata;
    logic           sram_we;
    logic [BEW-1:0] sram_be;
    logic [DW-1:0]  sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    generic_sram_byte_en_arb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_p0_req            (p0_req),
        .i_p0_we             (p0_we),
        .i_p0_addr           (p0_addr),
        .i_p0_wdata          (p0_wdata),
        .i_p0_be             (p0_be),
        .o_p0_gnt            (p0_gnt),
        .o_p0_rvalid         (p0_rvalid),
        .o_p0_rdata          (p0_rdata),
        .i_p1_req            (p1_req),
        .i_p1_we             (p1_we),
        .i_p1_addr           (p1_addr),
        .i_p1_wdata          (p1_wdata),
        .i_p1_be             (p1_be),
        .o_p1_gnt            (p1_gnt),
        .o_p1_rvalid         (p1_rvalid),
        .o_p1_rdata          (p1_rdata),
        .o_sram_address      (sram_addr),
        .o_sram_write_data   (sram_wdata),
        .o_sram_write_enable (sram_we),
        .o_sram_byte_enable  (sram_be),
        .i_sram_read_data    (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-enabled write, registered read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        sram_rdata = '0;
    end
    always @(posedge clk) begin
        sram_rdata <= mem[sram_addr];
        if (sram_we) begin
            for (int b = 0; b < BEW; b++) begin
                if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [BEW-1:0] be);
        if (!port) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
        end
    endtask

    typedef struct {
        bit             port;
        bit             we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [BEW-1:0] be;
        logic [DW-1:0]  exp_rdata;
    } vec_t;

    // One access: request until granted, check SRAM pins at G+1, check read return at G+2
    task automatic access(input vec_t v);
        int n;
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.be);
        #1;
        check("idle_rvalid0", p0_rvalid, 0);
        check("idle_rvalid1", p1_rvalid, 0);
        check("idle_rdata", p0_rdata | p1_rdata, 0);
        n = 0;
        while (!(v.port ? p1_gnt : p0_gnt) && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 16) begin
            check("grant_timeout", 0, 1);
            drive(v.port, 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        check("other_gnt_low", v.port ? p0_gnt : p1_gnt, 0);
        @(negedge clk);
        drive(v.port, 1'b0, v.we, v.addr, v.wdata, v.be);
        check("sram_we", sram_we, v.we);
        check("sram_addr", sram_addr, v.addr);
        check("sram_be", sram_be, v.we ? v.be : '0);
        if (v.we) check("sram_wdata", sram_wdata, v.wdata);
        check("rvalid_early", v.port ? p1_rvalid : p0_rvalid, 0);
        @(negedge clk);
        check("sram_we_idle", sram_we, 0);
        check("rvalid_owner", v.port ? p1_rvalid : p0_rvalid, !v.we);
        check("rvalid_other", v.port ? p0_rvalid : p1_rvalid, 0);
        check("rdata", v.port ? p1_rdata : p0_rdata, v.we ? '0 : v.exp_rdata);
    endtask

    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] D7   = 128'hAABBCCDD_EEFF0011_22334455_66778899;
    localparam logic [DW-1:0] E7   = 128'h00000000_00000000_22334455_00000000;
    localparam logic [DW-1:0] D127 = 128'h80000000_00000000_00000000_00000001;

    vec_t vecs [12];
    logic [7:0] eg0, eg1;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 7'd5,   128'hCAFE, 16'hFFFF, '0};
        vecs[1]  = '{1'b0, 1'b0, 7'd5,   '0,        16'h0,    128'hCAFE};
        vecs[2]  = '{1'b0, 1'b1, 7'd3,   '0,        16'hFFFF, '0};
        vecs[3]  = '{1'b0, 1'b1, 7'd3,   ONES,      16'h0001, '0};
        vecs[4]  = '{1'b0, 1'b0, 7'd3,   '0,        16'h0,    128'hFF};
        vecs[5]  = '{1'b1, 1'b1, 7'd7,   D7,        16'h00F0, '0};
        vecs[6]  = '{1'b1, 1'b0, 7'd7,   '0,        16'h0,    E7};
        vecs[7]  = '{1'b0, 1'b1, 7'd7,   ONES,      16'h0000, '0};
        vecs[8]  = '{1'b1, 1'b0, 7'd7,   '0,        16'h0,    E7};
        vecs[9]  = '{1'b0, 1'b1, 7'd127, D127,      16'hFFFF, '0};
        vecs[10] = '{1'b0, 1'b0, 7'd0,   '0,        16'h0,    '0};
        vecs[11] = '{1'b1, 1'b0, 7'd127, '0,        16'h0,    D127};

        // Reset state, with a request held to confirm that grants are suppressed
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        #3;
        check("rst_gnt0", p0_gnt, 0);
        check("rst_gnt1", p1_gnt, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_sram_be", sram_be, 0);
        check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        check("rst_rdata", p0_rdata | p1_rdata, 0);
        p0_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) access(vecs[i]);

        // Contention: both requesters read for 4 cycles (p0 addr 5, p1 addr 3)
`ifdef GENERIC_SRAM_BYTE_EN_ARB_RR_EN
        eg0 = 8'b0000_0101;
        eg1 = 8'b0000_1010;
`else
        eg0 = 8'b0000_1111;
        eg1 = 8'b0001_0000;
`endif
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(1'b0, c < 4, 1'b0, 7'd5, '0, '0);
`ifdef GENERIC_SRAM_BYTE_EN_ARB_RR_EN
            drive(1'b1, c < 4, 1'b0, 7'd3, '0, '0);
`else
            drive(1'b1, c < 5, 1'b0, 7'd3, '0, '0);
`endif
            #1;
            check($sformatf("cont_gnt0_c%0d", c), p0_gnt, eg0[c]);
            check($sformatf("cont_gnt1_c%0d", c), p1_gnt, eg1[c]);
            if (c >= 2) begin
                check($sformatf("cont_rvalid0_c%0d", c), p0_rvalid, eg0[c-2]);
                check($sformatf("cont_rvalid1_c%0d", c), p1_rvalid, eg1[c-2]);
                check($sformatf("cont_rdata0_c%0d", c), p0_rdata, eg0[c-2] ? 128'hCAFE : '0);
                check($sformatf("cont_rdata1_c%0d", c), p1_rdata, eg1[c-2] ? 128'hFF : '0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);

        // Read-after-write: p0 writes addr 9 in G, p1 reads addr 9 in G+1
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 7'd9, 128'h11, 16'hFFFF);
        drive(1'b1, 1'b1, 1'b0, 7'd9, '0, '0);
        #1;
        check("raw_gnt0_G", p0_gnt, 1);
        check("raw_gnt1_G", p1_gnt, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check("raw_gnt1_G1", p1_gnt, 1);
        check("raw_gnt0_G1", p0_gnt, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("raw_sram_we_G2", sram_we, 0);
        check("raw_sram_addr_G2", sram_addr, 9);
        @(negedge clk);
        check("raw_rvalid1_G3", p1_rvalid, 1);
        check("raw_rdata1_G3", p1_rdata, 128'h11);
        check("raw_rvalid0_G3", p0_rvalid, 0);

        // Reset one cycle after a p1 read grant
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 7'd9, '0, '0);
        #1;
        check("rstmid_gnt1_G", p1_gnt, 1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b0, 1'b1, 1'b0, 7'd5, '0, '0);
        rst_n = 1'b0;
        #1;
        check("rstmid_gnt0", p0_gnt, 0);
        check("rstmid_gnt1", p1_gnt, 0);
        check("rstmid_sram_we", sram_we, 0);
        check("rstmid_sram_addr", sram_addr, 0);
        check("rstmid_sram_wdata", sram_wdata, 0);
        check("rstmid_sram_be", sram_be, 0);
        check("rstmid_rvalid", {p0_rvalid, p1_rvalid}, 0);
        check("rstmid_rdata", p0_rdata | p1_rdata, 0);
        @(negedge clk);
        check("rstmid_rvalid1_G2", p1_rvalid, 0);
        check("rstmid_rdata1_G2", p1_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 7'd3, '0, '0);
        #1;
        check("rel_gnt0", p0_gnt, 1);
        check("rel_gnt1", p1_gnt, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("rel_sram_addr", sram_addr, 5);
        check("rel_rvalid1_R1", p1_rvalid, 0);
        @(negedge clk);
        check("rel_rvalid0_R2", p0_rvalid, 1);
        check("rel_rdata0_R2", p0_rdata, 128'hCAFE);
        check("rel_rvalid1_R2", p1_rvalid, 0);
        @(negedge clk);
        check("rel_rvalid_R3", {p0_rvalid, p1_rvalid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
